// File: rtl/fsgn_pipe.sv
// Sign-injection unit (FSGNJ/FSGNJN/FSGNJX/FABS/FNEG/FMV) with an elastic
// valid/ready pipeline of STAGES slots; the result is formed before slot 0.
module fsgn_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nan,
  output logic             out_illegal
);

  localparam int unsigned EXP_W = (WIDTH == 64) ? 11 : 8;
  localparam int unsigned MAN_W = WIDTH - 1 - EXP_W;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             nan;
    logic             ill;
  } slot_t;

  logic                w_s;
  logic                w_t;
  logic                w_sign;
  slot_t               w_in;
  slot_t [STAGES-1:0]  r_slot;
  slot_t [STAGES-1:0]  w_src;
  logic  [STAGES-1:0]  r_valid;
  logic  [STAGES-1:0]  w_valid_d;
  logic  [STAGES-1:0]  w_src_v;
  // w_take[k]: slot k loads this cycle; w_take[STAGES]: output transfer
  logic  [STAGES:0]    w_take;

  always_comb begin
    w_s      = in_a[WIDTH-1];
    w_t      = in_b[WIDTH-1];
    w_sign   = w_s;
    w_in.ill = 1'b0;
    case (in_op)
      3'b000:  w_sign = w_t;
      3'b001:  w_sign = ~w_t;
      3'b010:  w_sign = w_s ^ w_t;
      3'b011:  w_sign = 1'b0;
      3'b100:  w_sign = ~w_s;
      3'b101:  w_sign = w_s;
      default: begin
        w_sign   = w_s;
        w_in.ill = 1'b1;
      end
    endcase
    w_in.res = {w_sign, in_a[WIDTH-2:0]};
    w_in.tag = in_tag;
    w_in.nan = (&in_a[WIDTH-2 -: EXP_W]) & (|in_a[MAN_W-1:0]);
  end

  // Slot k is fed from slot k-1, slot 0 from the freshly computed result.
  if (STAGES > 1) begin : g_chain
    assign w_src   = {r_slot[STAGES-2:0], w_in};
    assign w_src_v = {r_valid[STAGES-2:0], in_valid & ~rst};
  end else begin : g_single
    assign w_src   = w_in;
    assign w_src_v = in_valid & ~rst;
  end

  // Ready ripples back from out_ready so a full pipe still streams every cycle.
  always_comb begin
    w_take         = '0;
    w_valid_d      = '0;
    w_take[STAGES] = r_valid[STAGES-1] & out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      w_take[k]    = w_src_v[k] & (~r_valid[k] | w_take[k+1]);
      w_valid_d[k] = w_take[k] | (r_valid[k] & ~w_take[k+1]);
    end
  end

  assign in_ready = ~rst & (~r_valid[0] | w_take[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(STAGES); k++) begin
      if (w_take[k]) begin
        r_slot[k] <= w_src[k];
      end
    end
  end

  assign out_valid   = r_valid[STAGES-1];
  assign out_res     = r_slot[STAGES-1].res;
  assign out_tag     = r_slot[STAGES-1].tag;
  assign out_nan     = r_slot[STAGES-1].nan;
  assign out_illegal = r_slot[STAGES-1].ill;

endmodule

// File: doc/fsgn_pipe.md
FSGN_PIPE -- requirements
Module: fsgn_pipe

Interface
REQ-001 Parameter WIDTH, default 32, meaning float operand width, legal values 32 (sign bit 31) and 64 (sign bit 63).
REQ-002 Parameter STAGES, default 2, meaning pipeline depth in registers, legal 1..4.
REQ-003 Parameter TAG_W, default 4, meaning width of opaque sideband tag carried with each operation.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit accepts request this cycle.
REQ-008 in_op  input  3  operation code (REQ-013).
REQ-009 in_a, in_b  input  WIDTH each  operand a (magnitude source), operand b (sign source).
REQ-010 in_tag  input  TAG_W  sideband tag.
REQ-011 out_valid, out_ready  output/input  1 each  result handshake.
REQ-012 out_res  output  WIDTH; out_tag  output  TAG_W; out_nan  output 1 (operand a is NaN: exponent all-ones, mantissa nonzero); out_illegal  output 1 (op code undefined).

Function
REQ-013 Op codes, s = sign of a, t = sign of b, m = a without sign: 000 FSGNJ {t,m}; 001 FSGNJN {~t,m}; 010 FSGNJX {s^t,m}; 011 FABS {0,m}; 100 FNEG {~s,m}; 101 FMV {s,m}; 110/111 illegal -> result {s,m}, out_illegal=1.
REQ-014 Operand bits other than the sign shall pass unmodified, including NaN payloads; no canonicalisation, no exception flags besides out_nan/out_illegal.
REQ-015 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Pipeline shall be STAGES register slots, each with a valid bit; result computed combinationally before slot 0.
REQ-017 Slot k shall load from slot k-1 (or input for k=0) when slot k is empty or slot k advances in the same cycle; a slot advances when the downstream slot loads or, for the last slot, an output transfer occurs.
REQ-018 in_ready = slot 0 empty OR slot 0 advances this cycle (combinational from out_ready through the chain); no bubble insertion under continuous flow.
REQ-019 Latency: a request accepted in cycle n with no stall shall present out_valid in cycle n+STAGES.
REQ-020 Throughput: one result per cycle while in_valid and out_ready both held high.
REQ-021 With out_ready low, out_valid and all out_* shall hold stable until transfer; the pipeline shall fill to STAGES entries then deassert in_ready.
REQ-022 Simultaneous output transfer and input transfer with all slots full shall be accepted in the same cycle with no loss or duplication.
REQ-023 Ordering: results leave in acceptance order; out_tag shall equal the in_tag of the matching request.
REQ-024 out_res/out_tag/out_nan/out_illegal are don't-care when out_valid=0; datapath registers need no reset.
REQ-025 Occupancy never exceeds STAGES; no overflow or underflow state exists.

Reset
REQ-026 While rst=1 all slot valid bits shall clear at the next edge; out_valid=0 the cycle after rst sampled high.
REQ-027 in_ready shall read 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-028 Reset mid-operation shall discard all in-flight requests; none shall appear after reset.

Verification
REQ-029 WIDTH=32, STAGES=2: op 011, a=0xBF800000 accepted cycle 0 -> cycle 2 out_valid=1, out_res=0x3F800000, out_nan=0.
REQ-030 WIDTH=64: op 010, a=0xC000000000000000, b=0x8000000000000000 -> out_res=0x4000000000000000; op 000 same operands -> 0xC000000000000000.
REQ-031 op 100, a=0x7FC00001 -> out_res=0xFFC00001, out_nan=1; op 111, a=0x12345678 -> out_res=0x12345678, out_illegal=1.
REQ-032 STAGES=3, out_ready=0, stream tags 1..5 with in_valid=1 -> exactly 3 accepted, in_ready=0 thereafter; raise out_ready -> tags 1..5 emerge in order, one per cycle, none lost or repeated.
REQ-033 Random in_valid/out_ready (50% each), 10000 ops, all op codes, against golden bit model -> zero mismatches, order preserved.
REQ-034 Assert rst for 1 cycle with 2 entries in flight -> out_valid=0 next cycle, no stale result afterward, in_ready=1 the cycle after rst falls.
